// File: rtl/cam_to_ram_if.sv
// cam_to_ram_if: camera input bus and frame-RAM write port bundle for cam_to_ram
interface cam_to_ram_if #(
    parameter int ADDR_W = 17
);
    logic              capture_en_i;
    logic              cam_vsync_i;
    logic              cam_href_i;
    logic [7:0]        cam_data_i;
    logic              ram_wr_en_o;
    logic [ADDR_W-1:0] ram_wr_addr_o;
    logic [15:0]       ram_wr_data_o;
    logic              busy_o;
    logic              frame_done_o;
    logic              frame_err_o;

    modport master (
        output capture_en_i, cam_vsync_i, cam_href_i, cam_data_i,
        input  ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, busy_o, frame_done_o, frame_err_o
    );

    modport slave (
        input  capture_en_i, cam_vsync_i, cam_href_i, cam_data_i,
        output ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, busy_o, frame_done_o, frame_err_o
    );
endinterface

// File: rtl/cam_to_ram.sv
// cam_to_ram: packs camera byte pairs into RGB565 and writes a cropped window linearly to frame RAM
module cam_to_ram #(
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272,
    parameter int H_START  = 0,
    parameter int V_START  = 0,
    parameter int ADDR_W   = 17
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    cam_to_ram_if.slave bus
);
    localparam logic [15:0]     H_LO  = 16'(H_START);
    localparam logic [15:0]     H_HI  = 16'(H_START + H_ACTIVE);
    localparam logic [15:0]     V_LO  = 16'(V_START);
    localparam logic [15:0]     V_HI  = 16'(V_START + V_ACTIVE);
    localparam logic [ADDR_W:0] TOTAL = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {S_WAIT_VS_HI, S_WAIT_VS_LO, S_FRAME} state_t;

    state_t            r_state, w_next;
    logic              r_vsync, r_href, r_vsync_d, r_href_d;
    logic [7:0]        r_data, r_hi;
    logic [15:0]       r_line, r_pcnt, r_pix;
    logic              r_phase, r_bad, r_pix_vld;
    logic              r_wr_en, r_end, r_end_d, r_done, r_err;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;
    logic [ADDR_W:0]   r_wcnt;

    logic              w_vs_rise, w_vs_fall, w_href_rise, w_href_fall;
    logic              w_start, w_in_frame, w_line_in, w_phase, w_keep, w_room;
    logic [15:0]       w_pcnt;

    assign w_vs_rise   = r_vsync & ~r_vsync_d;
    assign w_vs_fall   = ~r_vsync & r_vsync_d;
    assign w_href_rise = r_href & ~r_href_d;
    assign w_href_fall = ~r_href & r_href_d;
    assign w_in_frame  = r_state == S_FRAME;
    assign w_start     = r_state == S_WAIT_VS_LO && w_vs_fall && bus.capture_en_i;
    assign w_line_in   = r_line >= V_LO && r_line < V_HI;
    assign w_pcnt      = w_href_rise ? 16'd0 : r_pcnt;
    assign w_phase     = ~w_href_rise & r_phase;
    assign w_keep      = w_line_in && w_pcnt >= H_LO && w_pcnt < H_HI;
    assign w_room      = r_wcnt < TOTAL;

    assign bus.ram_wr_en_o   = r_wr_en;
    assign bus.ram_wr_addr_o = r_wr_addr;
    assign bus.ram_wr_data_o = r_wr_data;
    assign bus.busy_o        = w_in_frame;
    assign bus.frame_done_o  = r_done;
    assign bus.frame_err_o   = r_err;

    // Register the camera bus once and keep a delayed copy for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_vsync   <= 1'b0;
            r_href    <= 1'b0;
            r_data    <= 8'd0;
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
        end else begin
            r_vsync   <= bus.cam_vsync_i;
            r_href    <= bus.cam_href_i;
            r_data    <= bus.cam_data_i;
            r_vsync_d <= r_vsync;
            r_href_d  <= r_href;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_state <= S_WAIT_VS_HI;
        else          r_state <= w_next;
    end

    // Frame sequencing: arm on VSYNC fall, close the frame on VSYNC rise
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_VS_HI: w_next = r_vsync ? S_WAIT_VS_LO : S_WAIT_VS_HI;
            S_WAIT_VS_LO: w_next = !w_vs_fall ? S_WAIT_VS_LO : bus.capture_en_i ? S_FRAME : S_WAIT_VS_HI;
            S_FRAME:      w_next = w_vs_rise ? S_WAIT_VS_LO : S_FRAME;
            default:      w_next = S_WAIT_VS_HI;
        endcase
    end

    // Byte pairing, line/pixel counting, window test and bad-line tracking
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_line    <= 16'd0;
            r_pcnt    <= 16'd0;
            r_phase   <= 1'b0;
            r_hi      <= 8'd0;
            r_bad     <= 1'b0;
            r_pix     <= 16'd0;
            r_pix_vld <= 1'b0;
        end else begin
            r_pix_vld <= 1'b0;
            if (w_start) begin
                r_line  <= 16'd0;
                r_pcnt  <= 16'd0;
                r_phase <= 1'b0;
                r_bad   <= 1'b0;
            end else if (w_in_frame) begin
                if (r_href) begin
                    r_phase <= ~w_phase;
                    r_pcnt  <= w_phase ? w_pcnt + 16'd1 : w_pcnt;
                    if (!w_phase) r_hi <= r_data;
                    else begin
                        r_pix     <= {r_hi, r_data};
                        r_pix_vld <= w_keep;
                    end
                end
                if (w_href_fall) begin
                    r_line <= r_line + 16'd1;
                    if (w_line_in && (r_phase || r_pcnt < H_HI)) r_bad <= 1'b1;
                end
            end
        end
    end

    // RAM write port: one strobe per kept pixel, address advances after each write
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 16'd0;
            r_wcnt    <= '0;
        end else begin
            r_wr_en <= r_pix_vld && w_room;
            if (w_start) begin
                r_wr_addr <= '0;
                r_wcnt    <= '0;
            end else if (r_pix_vld && w_room) begin
                r_wr_addr <= r_wcnt[ADDR_W-1:0];
                r_wr_data <= r_pix;
                r_wcnt    <= r_wcnt + ONE;
            end
        end
    end

    // End-of-frame verdict, delayed so a last in-flight write is counted first
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_end   <= 1'b0;
            r_end_d <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_end   <= w_in_frame & w_vs_rise;
            r_end_d <= r_end;
            r_done  <= r_end_d & ~r_bad & (r_wcnt == TOTAL);
            r_err   <= r_end_d & (r_bad | (r_wcnt != TOTAL));
        end
    end
endmodule

// File: tb/tb_cam_to_ram.sv
// tb_cam_to_ram: directed frames against a small 4x3 window at offset (1,2)
module tb_cam_to_ram;
    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    int          total = 0;
    int          fails = 0;
    int          wr_cnt, done_cnt, err_cnt, busy_cnt, ord_err, both;
    logic [15:0] mem [16];

    cam_to_ram_if #(.ADDR_W(AW)) bus ();

    cam_to_ram #(
        .H_ACTIVE(4), .V_ACTIVE(3), .H_START(1), .V_START(2), .ADDR_W(AW)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Write log sampled on the falling edge
    always @(negedge clk) begin
        if (clr || !rst_n) begin
            wr_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; ord_err = 0; both = 0;
            for (int i = 0; i < 16; i++) mem[i] = 16'd0;
        end else begin
            if (bus.ram_wr_en_o) begin
                if (bus.ram_wr_addr_o != AW'(wr_cnt)) ord_err++;
                mem[bus.ram_wr_addr_o] = bus.ram_wr_data_o;
                wr_cnt++;
            end
            if (bus.frame_done_o) done_cnt++;
            if (bus.frame_err_o) err_cnt++;
            if (bus.frame_done_o && bus.frame_err_o) both++;
            if (bus.busy_o) busy_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bus.cam_href_i = 1'b1;
        bus.cam_data_i = b;
        idle(1);
    endtask

    // One camera frame: npix pixels per line, nl lines; odd_l drops the last byte of that line,
    // rst_l pulses reset mid-line, lat replaces window pixel (2,1) with 0xF8,0x1F and checks timing
    task automatic cam_frame(input int npix, input int nl, input int odd_l, input int rst_l,
                             input bit en, input bit lat);
        bus.cam_vsync_i  = 1'b1;
        bus.capture_en_i = en;
        idle(3);
        bus.cam_vsync_i = 1'b0;
        idle(2);
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < 2 * npix - (l == odd_l ? 1 : 0); b++) begin
                int p;
                logic [7:0] v;
                p = b / 2;
                v = b[0] ? 8'(p) : 8'(l);
                if (lat && l == 2 && p == 1) v = b[0] ? 8'h1F : 8'hF8;
                rst_n = !(l == rst_l && b == 3);
                drive_byte(v);
                if (lat && l == 2 && b == 4) chk("lat_k1_en", bus.ram_wr_en_o, 0);
                if (lat && l == 2 && b == 5) begin
                    chk("lat_k2_en", bus.ram_wr_en_o, 1);
                    chk("lat_k2_data", bus.ram_wr_data_o, 16'hF81F);
                    chk("lat_k2_addr", bus.ram_wr_addr_o, 0);
                end
            end
            rst_n = 1'b1;
            bus.cam_href_i = 1'b0;
            idle(3);
        end
        bus.cam_vsync_i = 1'b1;
        idle(8);
    endtask

    initial begin
        bus.capture_en_i = 1'b0;
        bus.cam_vsync_i  = 1'b0;
        bus.cam_href_i   = 1'b0;
        bus.cam_data_i   = 8'd0;
        idle(3);
        chk("rst_wr_en", bus.ram_wr_en_o, 0);
        chk("rst_addr", bus.ram_wr_addr_o, 0);
        chk("rst_data", bus.ram_wr_data_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.frame_done_o, 0);
        chk("rst_err", bus.frame_err_o, 0);
        rst_n = 1'b1;
        idle(2);

        clear_log();
        cam_frame(6, 6, -1, -1, 1'b1, 1'b0);
        chk("f1_writes", wr_cnt, 12);
        chk("f1_done", done_cnt, 1);
        chk("f1_err", err_cnt, 0);
        chk("f1_order", ord_err, 0);
        chk("f1_first", mem[0], 16'h0201);
        chk("f1_mid", mem[5], 16'h0302);
        chk("f1_last", mem[11], 16'h0404);
        chk("f1_addr_hold", bus.ram_wr_addr_o, 11);
        chk("f1_busy_seen", busy_cnt != 0, 1);
        chk("f1_busy_after", bus.busy_o, 0);

        clear_log();
        cam_frame(6, 6, -1, -1, 1'b0, 1'b0);
        chk("skip_writes", wr_cnt, 0);
        chk("skip_busy", busy_cnt, 0);
        chk("skip_done", done_cnt, 0);
        chk("skip_err", err_cnt, 0);

        clear_log();
        cam_frame(8, 8, -1, -1, 1'b1, 1'b0);
        chk("big_writes", wr_cnt, 12);
        chk("big_done", done_cnt, 1);
        chk("big_last", mem[11], 16'h0404);
        chk("big_order", ord_err, 0);

        clear_log();
        cam_frame(6, 6, 3, -1, 1'b1, 1'b0);
        chk("odd_writes", wr_cnt, 12);
        chk("odd_err", err_cnt, 1);
        chk("odd_done", done_cnt, 0);

        clear_log();
        cam_frame(4, 6, -1, -1, 1'b1, 1'b0);
        chk("short_writes", wr_cnt, 9);
        chk("short_err", err_cnt, 1);
        chk("short_done", done_cnt, 0);

        clear_log();
        cam_frame(6, 3, -1, -1, 1'b1, 1'b0);
        chk("few_writes", wr_cnt, 4);
        chk("few_err", err_cnt, 1);
        chk("few_done", done_cnt, 0);

        clear_log();
        cam_frame(6, 6, -1, 3, 1'b1, 1'b0);
        chk("rst_mid_writes", wr_cnt, 0);
        chk("rst_mid_done", done_cnt, 0);
        chk("rst_mid_err", err_cnt, 0);
        chk("rst_mid_busy", busy_cnt, 0);

        clear_log();
        cam_frame(6, 6, -1, -1, 1'b1, 1'b1);
        chk("post_writes", wr_cnt, 12);
        chk("post_done", done_cnt, 1);
        chk("post_err", err_cnt, 0);
        chk("post_first", mem[0], 16'hF81F);
        chk("post_order", ord_err, 0);

        chk("never_both", both, 0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
